// File: rtl/pf_pkg.sv
// pf_pkg: shared constants, FSM state type and the bank byte-select helper
// used by the playfield fetch block (pf_fetch) and its address generator.
package pf_pkg;

  // Playfield geometry in tiles and pixels.
  localparam int H_TILES     = 32;
  localparam int V_TILES_DEF = 30;
  localparam int TILE_W      = 8;

  // Port-B bank enables are active low: all banks read together or all idle.
  localparam logic [3:0] CE_IDLE = 4'b1111;
  localparam logic [3:0] CE_READ = 4'b0000;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    CAPT = 2'd2,
    WAIT = 2'd3
  } fetch_state_e;

  // Pick one byte lane out of the 32-bit port-B word.
  // Lane 3 is [31:24] down to lane 0 on [7:0].
  function automatic logic [7:0] bank_byte(input logic [31:0] word,
                                           input logic [1:0]  sel);
    logic [7:0] b;
    case (sel)
      2'd3:    b = word[31:24];
      2'd2:    b = word[23:16];
      2'd1:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pf_addr_gen.sv
// pf_addr_gen: combinational fetch-trigger detection and playfield address
// generation. Decides on which hcount/vcount a tile fetch is launched, which
// row/column it targets, and maps that to the 10-bit playfield address
// {row, col} plus the pixel row inside the tile.
// Optional build macro: PF_FLIP_EN (adds the flip_i input for cocktail flip).
module pf_addr_gen
  import pf_pkg::*;
#(
  parameter int V_TILES   = V_TILES_DEF,
  parameter int PRELOAD_H = 380,
  parameter int V_TOTAL   = 264
) (
  input  logic [8:0] hcount_i,
  input  logic [8:0] vcount_i,
`ifdef PF_FLIP_EN
  input  logic       flip_i,
`endif
  output logic       trig_o,
  output logic [9:0] pfaddr_o,
  output logic [2:0] yofs_o
);

  // Number of visible lines (vcount 0 .. VIS_LINES-1).
  localparam logic [9:0] VIS_LINES  = 10'(V_TILES * TILE_W);
  // In-line fetches stop once column 31 has been requested (hcount 244).
  localparam logic [8:0] T1_LIMIT   = 9'((H_TILES - 1) * TILE_W);
  localparam logic [8:0] PRELOAD_AT = 9'(PRELOAD_H);
  // Last line of the frame; the line after it is line 0.
  localparam logic [8:0] LAST_LINE  = 9'(V_TOTAL - 1);
  localparam logic [4:0] ROW_MAX    = 5'(V_TILES - 1);
  localparam logic [4:0] COL_MAX    = 5'(H_TILES - 1);

  logic [9:0] next_v;
  logic       t1_hit;
  logic       t2_hit;
  logic [4:0] row;
  logic [4:0] col;
  logic [2:0] yofs_raw;

  // Trigger detection and unflipped row/column selection.
  always_comb begin
    next_v   = (vcount_i == LAST_LINE) ? 10'd0 : ({1'b0, vcount_i} + 10'd1);
    // In-line fetch: half-way through a tile, request the next column.
    t1_hit   = (hcount_i[2:0] == 3'b100) && (hcount_i < T1_LIMIT) &&
               ({1'b0, vcount_i} < VIS_LINES);
    // Preload: column 0 of the following line, launched during hblank.
    t2_hit   = (hcount_i == PRELOAD_AT) && (next_v < VIS_LINES);
    if (t2_hit) begin
      row      = next_v[7:3];
      col      = 5'd0;
      yofs_raw = next_v[2:0];
    end else begin
      row      = vcount_i[7:3];
      col      = hcount_i[7:3] + 5'd1;
      yofs_raw = vcount_i[2:0];
    end
    trig_o = (t1_hit || t2_hit) && (row <= ROW_MAX);
  end

`ifdef PF_FLIP_EN
  // Cocktail flip mirrors the tile grid and the pixel row inside a tile.
  always_comb begin
    if (flip_i) begin
      pfaddr_o = {ROW_MAX - row, COL_MAX - col};
      yofs_o   = 3'd7 - yofs_raw;
    end else begin
      pfaddr_o = {row, col};
      yofs_o   = yofs_raw;
    end
  end
`else
  assign pfaddr_o = {row, col};
  assign yofs_o   = yofs_raw;
`endif

endmodule

// File: rtl/pf_fetch.sv
// pf_fetch: video-side reader of the playfield RAM 32-bit port B. Walks the
// 32x30 tile map one tile ahead of the beam, issues address and bank enables,
// selects the addressed byte lane and presents a registered tile code that
// changes exactly on each 8-pixel tile boundary.
// Optional build macro: PF_FLIP_EN (adds the flip input for cocktail flip).
module pf_fetch
  import pf_pkg::*;
#(
  parameter int H_TOTAL   = 384,
  parameter int V_TILES   = V_TILES_DEF,
  parameter int PRELOAD_H = 380,
  parameter int V_TOTAL   = 264
) (
  input  logic        clk,
  input  logic        reset,
`ifdef PF_FLIP_EN
  input  logic        flip,
`endif
  input  logic [8:0]  hcount,
  input  logic [8:0]  vcount,
  output logic [7:0]  addr_b,
  output logic [3:0]  ce_b,
  input  logic [31:0] dout_b,
  output logic [7:0]  tile_code,
  output logic [2:0]  tile_yofs,
  output logic        tile_valid,
  output logic        fetch_busy
);

  // Last pixel of the visible 256-pixel span; tile_valid drops after it.
  localparam logic [8:0] RIGHT_EDGE = 9'(H_TILES * TILE_W - 1);
  // Last pixel of the line; the column-0 preload is presented here.
  localparam logic [8:0] LAST_PIX   = 9'(H_TOTAL - 1);

  logic       trig;
  logic [9:0] pfaddr;
  logic [2:0] yofs;

  fetch_state_e state_q, state_d;
  logic [7:0]   addr_q, addr_d;
  logic [3:0]   ce_q, ce_d;
  logic [1:0]   bsel_q, bsel_d;
  logic [2:0]   yofs_lat_q, yofs_lat_d;
  logic [7:0]   pend_q, pend_d;
  logic [7:0]   code_q, code_d;
  logic [2:0]   tyofs_q, tyofs_d;
  logic         valid_q, valid_d;

  pf_addr_gen #(
    .V_TILES   (V_TILES),
    .PRELOAD_H (PRELOAD_H),
    .V_TOTAL   (V_TOTAL)
  ) u_addr_gen (
    .hcount_i (hcount),
    .vcount_i (vcount),
`ifdef PF_FLIP_EN
    .flip_i   (flip),
`endif
    .trig_o   (trig),
    .pfaddr_o (pfaddr),
    .yofs_o   (yofs)
  );

  // Fetch sequencer: launch, wait for RAM data, capture, present on boundary.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ce_d       = ce_q;
    bsel_d     = bsel_q;
    yofs_lat_d = yofs_lat_q;
    pend_d     = pend_q;
    code_d     = code_q;
    tyofs_d    = tyofs_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        if (trig) begin
          addr_d     = pfaddr[7:0];
          ce_d       = CE_READ;
          bsel_d     = pfaddr[9:8];
          yofs_lat_d = yofs;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        // The RAM samples the address at the end of this cycle, so the
        // enables are only needed for this one clock.
        ce_d    = CE_IDLE;
        state_d = CAPT;
      end
      CAPT: begin
        pend_d  = bank_byte(dout_b, bsel_q);
        ce_d    = CE_IDLE;
        state_d = WAIT;
      end
      WAIT: begin
        if (hcount[2:0] == 3'b111) begin
          // Present only for visible columns or the column-0 preload.
          if ((hcount < RIGHT_EDGE) || (hcount == LAST_PIX)) begin
            code_d  = pend_q;
            tyofs_d = yofs_lat_q;
            valid_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Past the right edge the held code no longer belongs to a visible tile.
    if (hcount == RIGHT_EDGE) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers; reset aborts any fetch in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      ce_q       <= CE_IDLE;
      bsel_q     <= '0;
      yofs_lat_q <= '0;
      pend_q     <= '0;
      code_q     <= '0;
      tyofs_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ce_q       <= ce_d;
      bsel_q     <= bsel_d;
      yofs_lat_q <= yofs_lat_d;
      pend_q     <= pend_d;
      code_q     <= code_d;
      tyofs_q    <= tyofs_d;
      valid_q    <= valid_d;
    end
  end

  // A trigger can only land in IDLE: 4-clock pipeline against 8-clock cadence.
  assert property (@(posedge clk) disable iff (reset)
                   !(trig && (state_q != IDLE)));

  assign addr_b     = addr_q;
  assign ce_b       = ce_q;
  assign tile_code  = code_q;
  assign tile_yofs  = tyofs_q;
  assign tile_valid = valid_q;
  assign fetch_busy = (state_q == ADDR) || (state_q == CAPT);

endmodule

// File: tb/tb_pf_fetch.sv
// tb_pf_fetch: scoreboard bench for pf_fetch. The stimulus process drives the
// raster counters and, whenever a fetch should launch, pushes the expected tile
// code / row offset. A monitor pops and compares on every column boundary the
// DUT marks valid. Port-B RAM is modelled as four synchronous byte banks.
// Optional build macro: PF_FLIP_EN (adds a flipped-addressing pass).
module tb_pf_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  hcount;
  logic [8:0]  vcount;
  logic [7:0]  addr_b;
  logic [3:0]  ce_b;
  logic [31:0] dout_b = '0;
  logic [7:0]  tile_code;
  logic [2:0]  tile_yofs;
  logic        tile_valid;
  logic        fetch_busy;
`ifdef PF_FLIP_EN
  logic        flip;
`endif

  always #5 clk = ~clk;

  pf_fetch dut (
    .clk        (clk),
    .reset      (reset),
`ifdef PF_FLIP_EN
    .flip       (flip),
`endif
    .hcount     (hcount),
    .vcount     (vcount),
    .addr_b     (addr_b),
    .ce_b       (ce_b),
    .dout_b     (dout_b),
    .tile_code  (tile_code),
    .tile_yofs  (tile_yofs),
    .tile_valid (tile_valid),
    .fetch_busy (fetch_busy)
  );

  // Physical bank storage and the logical {row,col} tile map written alongside.
  logic [7:0] bank_mem [0:3][0:255];
  logic [7:0] tile_map [0:1023];

  // Port-B RAM: each enabled bank registers its byte on the rising edge.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!ce_b[b]) dout_b[8*b +: 8] <= bank_mem[b][addr_b];
    end
  end

  typedef struct {
    logic [7:0] code;
    logic [2:0] yofs;
    int         v;
    int         col;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fetches = 0;
  int   ce_low = 0;
  int   ce_run_err = 0;
  int   ce_bad = 0;
  int   busy_late = 0;
  bit   ce_prev_low = 1'b0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic poke(input int pa, input logic [7:0] val);
    bank_mem[pa >> 8][pa & 255] = val;
    tile_map[pa] = val;
  endtask

  // Drive one pixel clock; launch points follow the trigger rules directly.
  task automatic tick(input int v, input int h, input bit push_en);
    int   nv;
    int   row;
    int   col;
    int   yofs;
    int   disp_col;
    bit   hit;
    exp_t e;
    vcount = 9'(v);
    hcount = 9'(h);
    hit = 1'b0;
    row = 0; col = 0; yofs = 0;
    nv = (v == 263) ? 0 : v + 1;
    if ((h % 8) == 4 && h < 248 && v < 240) begin
      hit = 1'b1; row = v / 8; col = h / 8 + 1; yofs = v % 8;
    end else if (h == 380 && nv < 240) begin
      hit = 1'b1; row = nv / 8; col = 0; yofs = nv % 8;
    end
    if (hit) begin
      fetches++;
      disp_col = col;
`ifdef PF_FLIP_EN
      if (flip) begin
        row = 29 - row; col = 31 - col; yofs = 7 - yofs;
      end
`endif
      if (push_en) begin
        e.code = tile_map[row * 32 + col];
        e.yofs = 3'(yofs);
        e.v    = (h == 380) ? nv : v;
        e.col  = disp_col;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) tick(v, h, 1'b1);
  endtask

  // Monitor: enable-pulse shape, late-fetch detection and tile scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (ce_b == 4'b0000) begin
        ce_low++;
        if (ce_prev_low) ce_run_err++;
      end else if (ce_b != 4'b1111) begin
        ce_bad++;
      end
      ce_prev_low = (ce_b == 4'b0000);
      if (fetch_busy && hcount >= 9'd252 && hcount <= 9'd380) busy_late++;
      if (hcount[2:0] == 3'b000 && tile_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_tile: v=%0d h=%0d got code 0x%0h required none",
                   vcount, hcount, tile_code);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("tile_code v%0d c%0d", e.v, e.col), int'(tile_code), int'(e.code));
          check($sformatf("tile_yofs v%0d c%0d", e.v, e.col), int'(tile_yofs), int'(e.yofs));
          $display("tile v=%0d col=%0d code=%02h yofs=%0d", e.v, e.col, tile_code, tile_yofs);
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    hcount = 9'd0;
    vcount = 9'd300;
`ifdef PF_FLIP_EN
    flip   = 1'b0;
`endif
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++) bank_mem[b][a] = 8'h00;
    for (int i = 0; i < 1024; i++) tile_map[i] = 8'h00;
    poke(10'h005, 8'h5A);  // row 0 col 5, bank0
    poke(10'h105, 8'h3C);  // row 8 col 5, bank1
    poke(10'h003, 8'hA0);  // rows 0/8/16/24 col 3, one marker per bank
    poke(10'h103, 8'hA1);
    poke(10'h203, 8'hA2);
    poke(10'h303, 8'hA3);
    poke(10'h01F, 8'hE7);  // row 0 col 31, last visible column
    poke(10'h042, 8'h77);  // row 2 col 2, first fetch after the reset abort
    poke(10'h3A0, 8'h5E);  // row 29 col 0
    poke(10'h3BF, 8'hC5);  // row 29 col 31, flipped column 0 of row 0

    repeat (3) @(posedge clk);
    #1;
    check("rst_addr_b", int'(addr_b), 0);
    check("rst_ce_b", int'(ce_b), 4'b1111);
    check("rst_tile_code", int'(tile_code), 0);
    check("rst_tile_yofs", int'(tile_yofs), 0);
    check("rst_tile_valid", int'(tile_valid), 0);
    check("rst_fetch_busy", int'(fetch_busy), 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Last frame line preloads row 0; then row 0 and rows 8/16/24 at col 3/5.
    run_line(263, 0, 383);
    run_line(0, 0, 375);
    run_line(63, 376, 383);
    run_line(64, 0, 375);
    run_line(127, 376, 383);
    run_line(128, 0, 375);
    run_line(191, 376, 383);
    run_line(192, 0, 375);
    // Bottom visible row, then the whole vertical blank.
    run_line(238, 376, 383);
    run_line(239, 0, 383);
    for (int v = 240; v <= 263; v++) run_line(v, 0, 383);
    run_line(0, 0, 375);
    check("hold_code_after_edge", int'(tile_code), 8'hE7);
    check("hold_valid_after_edge", int'(tile_valid), 0);

    // Reset while the column-1 fetch is in ADDR.
    for (int h = 0; h < 4; h++) tick(16, h, 1'b1);
    tick(16, 4, 1'b0);
    reset = 1'b1;
    tick(16, 5, 1'b1);
    check("abort_ce_b", int'(ce_b), 4'b1111);
    check("abort_tile_valid", int'(tile_valid), 0);
    check("abort_tile_code", int'(tile_code), 0);
    check("abort_fetch_busy", int'(fetch_busy), 0);
    reset = 1'b0;
    tick(16, 6, 1'b1);
    tick(16, 7, 1'b1);
    check("abort_no_present", int'(tile_valid), 0);
    for (int h = 8; h <= 254; h++) tick(16, h, 1'b1);
    check("valid_before_edge", int'(tile_valid), 1);
    tick(16, 255, 1'b1);
    check("valid_fall_255", int'(tile_valid), 0);
    for (int h = 256; h <= 375; h++) tick(16, h, 1'b1);

`ifdef PF_FLIP_EN
    // Flipped pass: row 0 col 0 reads {29,31}, row offset mirrored to 7.
    flip = 1'b1;
    run_line(263, 376, 383);
    run_line(0, 0, 375);
    flip = 1'b0;
`endif

    check("queue_drained", exp_q.size(), 0);
    check("ce_low_per_fetch", ce_low, fetches);
    check("ce_single_cycle", ce_run_err, 0);
    check("ce_code_legal", ce_bad, 0);
    check("no_late_fetch", busy_late, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
